segment7_scan_counter: RTL and testbench



---
 rtl/segment7_pkg.sv | 30 +++
 rtl/segment7_digit_cnt.sv | 33 +++
 rtl/segment7_scan_counter.sv | 117 +++++++++++
 tb/tb_segment7_scan_counter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/segment7_pkg.sv
// Shared constants and helpers for the multi-digit seven-segment scan counter.
package segment7_pkg;

  // All segments dark on a common-anode display.
  localparam logic [6:0] SEG_OFF_AL = 7'h7F;

  // Active-low {a,b,c,d,e,f,g} patterns for nibbles 0..F (seg[6] = a).
  localparam logic [6:0] SEG_PATTERNS_AL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Nibble to segment pattern; non-decimal nibbles stay dark in decimal mode.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble,
                                            input logic       hex_mode,
                                            input logic       active_low);
    logic [6:0] pat;
    if (!hex_mode && (nibble > 4'd9)) pat = SEG_OFF_AL;
    else                              pat = SEG_PATTERNS_AL[nibble];
    return active_low ? pat : ~pat;
  endfunction

  // Saturate a nibble to a legal BCD digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > 4'd9) ? 4'd9 : nibble;
  endfunction

endpackage

// File: rtl/segment7_digit_cnt.sv
// One nibble of the up/down counter: steps when step_in is high and passes
// a carry (up) or borrow (down) to the next digit through step_out.
module segment7_digit_cnt #(
  parameter int HEX_MODE = 0
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       load,
  input  logic [3:0] load_nibble,
  input  logic       up,
  input  logic       step_in,
  output logic [3:0] value,
  output logic       step_out
);

  localparam logic [3:0] MAX_VAL = (HEX_MODE != 0) ? 4'hF : 4'h9;

  // The next digit steps only when this one steps across its boundary.
  assign step_out = step_in && (up ? (value == MAX_VAL) : (value == 4'h0));

  // Digit register: reset, then load, then increment/decrement with roll.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      value <= 4'h0;
    end else if (load) begin
      value <= load_nibble;
    end else if (step_in) begin
      if (up) value <= (value == MAX_VAL) ? 4'h0 : value + 4'h1;
      else    value <= (value == 4'h0) ? MAX_VAL : value - 4'h1;
    end
  end

endmodule

// File: rtl/segment7_scan_counter.sv
// Multi-digit up/down counter with a time-multiplexed seven-segment driver.
// The count steps once per TICK_DIV enabled cycles; the display strobes one
// digit for SCAN_DIV cycles at a time, independent of counting.
module segment7_scan_counter
  import segment7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 1000,
  parameter int SCAN_DIV       = 50,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    resetb,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : ~SEG_OFF_AL;

  logic [PW-1:0]       presc;
  logic                tick;
  logic [NUM_DIGITS:0] step;
  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       index;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                upper_zero;

  assign tick = en && (presc == PRESC_LAST);

  // Prescaler: free-runs while enabled, cleared by load.
  always_ff @(posedge clock) begin
    if (!resetb)                 presc <= '0;
    else if (load)               presc <= '0;
    else if (en && presc == PRESC_LAST) presc <= '0;
    else if (en)                 presc <= presc + PW'(1);
  end

  // Load wins over tick, so a tick in a load cycle never reaches the chain.
  assign step[0] = tick && !load;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [3:0] load_nibble;
    assign load_nibble = (HEX_MODE != 0) ? load_value[4*g +: 4]
                                         : bcd_clamp(load_value[4*g +: 4]);
    segment7_digit_cnt #(.HEX_MODE(HEX_MODE)) u_digit (
      .clock      (clock),
      .resetb     (resetb),
      .load       (load),
      .load_nibble(load_nibble),
      .up         (up),
      .step_in    (step[g]),
      .value      (count[4*g +: 4]),
      .step_out   (step[g+1])
    );
  end

  // Wrap pulses alongside the new count when the top digit rolls over/under.
  always_ff @(posedge clock) begin
    if (!resetb) wrap <= 1'b0;
    else         wrap <= step[NUM_DIGITS];
  end

  // Scan timer and digit index, unaffected by en and load.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      scan_cnt <= '0;
      index    <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      index    <= (index == IDX_LAST) ? '0 : index + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Select the strobed nibble and decide leading-zero blanking for it.
  always_comb begin
    cur_nib    = 4'h0;
    cur_blank  = 1'b0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (count[4*i +: 4] == 4'h0);
      if (index == IW'(i)) begin
        cur_nib   = count[4*i +: 4];
        cur_blank = blank_lz && upper_zero && (i != 0);
      end
    end
  end

  // Segment bus and strobe are registered together so digits never mix.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      seg     <= SEG_OFF;
      dig_sel <= '0;
    end else begin
      seg     <= cur_blank ? SEG_OFF
                           : seg_decode(cur_nib, HEX_MODE != 0, SEG_ACTIVE_LOW != 0);
      dig_sel <= NUM_DIGITS'(1) << index;
    end
  end

endmodule

// File: tb/tb_segment7_scan_counter.sv
// Directed bench for segment7_scan_counter: a 4-digit decimal instance,
// a 1-digit decimal instance and a 4-digit hex instance share the controls.
module tb_segment7_scan_counter;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0;
  logic        blank_lz = 1'b0;

  logic [6:0]  seg_d, seg_1, seg_h;
  logic [3:0]  dig_d, dig_h;
  logic [0:0]  dig_1;
  logic [15:0] cnt_d, cnt_h;
  logic [3:0]  cnt_1;
  logic        wrap_d, wrap_1, wrap_h;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [6:0] exp_pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  always #5 clock = ~clock;

  segment7_scan_counter #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(3),
                          .HEX_MODE(0), .SEG_ACTIVE_LOW(1)) dut (
    .clock(clock), .resetb(resetb), .en(en), .up(up), .load(load),
    .load_value(load_value), .blank_lz(blank_lz),
    .seg(seg_d), .dig_sel(dig_d), .count(cnt_d), .wrap(wrap_d));

  segment7_scan_counter #(.NUM_DIGITS(1), .TICK_DIV(4), .SCAN_DIV(2),
                          .HEX_MODE(0), .SEG_ACTIVE_LOW(1)) dut1 (
    .clock(clock), .resetb(resetb), .en(en), .up(up), .load(load),
    .load_value(load_value[3:0]), .blank_lz(blank_lz),
    .seg(seg_1), .dig_sel(dig_1), .count(cnt_1), .wrap(wrap_1));

  segment7_scan_counter #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(3),
                          .HEX_MODE(1), .SEG_ACTIVE_LOW(1)) duth (
    .clock(clock), .resetb(resetb), .en(en), .up(up), .load(load),
    .load_value(load_value), .blank_lz(blank_lz),
    .seg(seg_h), .dig_sel(dig_h), .count(cnt_h), .wrap(wrap_h));

  // Pulse load for one cycle; returns at the negedge after the load edge.
  task automatic do_load(input logic [15:0] value);
    load = 1'b1;
    load_value = value;
    @(negedge clock);
    load = 1'b0;
  endtask

  // Wait until the strobe has just moved from digit 3 to digit 0.
  task automatic sync_digit0();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = dig_d;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (dig_d == 4'b0001 && prev == 4'b1000) found = 1'b1;
      prev = dig_d;
    end
    total_cnt++;
    if (!found) $display("FAIL scan_sync: dig_sel=%b, digit 0 strobe not seen in 20 cycles", dig_d);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++; if (seg_d !== 7'h7F) $display("FAIL reset_seg: got %b expected %b", seg_d, 7'h7F); else pass_cnt++;
    total_cnt++; if (dig_d !== 4'b0000) $display("FAIL reset_dig: got %b expected %b", dig_d, 4'b0000); else pass_cnt++;
    total_cnt++; if (cnt_d !== 16'h0000) $display("FAIL reset_count: got %h expected %h", cnt_d, 16'h0000); else pass_cnt++;
    total_cnt++; if (wrap_d !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", wrap_d); else pass_cnt++;
    total_cnt++; if (seg_h !== 7'h7F) $display("FAIL reset_seg_hex: got %b expected %b", seg_h, 7'h7F); else pass_cnt++;
    resetb = 1'b1;
    en = 1'b1;
    up = 1'b1;
  endtask

  task automatic test_decimal_up();
    @(negedge clock);
    total_cnt++; if (dig_d !== 4'b0001) $display("FAIL first_strobe: got %b expected 0001", dig_d); else pass_cnt++;
    total_cnt++; if (seg_1 !== 7'b0000001) $display("FAIL first_seg: got %b expected 0000001", seg_1); else pass_cnt++;
    total_cnt++; if (cnt_1 !== 4'h0) $display("FAIL first_count_early: got %h expected 0", cnt_1); else pass_cnt++;
    repeat (3) @(negedge clock);
    for (int k = 1; k <= 10; k++) begin
      total_cnt++;
      if (cnt_1 !== 4'(k % 10)) $display("FAIL up_count step %0d: got %h expected %h", k, cnt_1, 4'(k % 10));
      else pass_cnt++;
      total_cnt++;
      if (wrap_1 !== (k == 10)) $display("FAIL up_wrap step %0d: got %b expected %b", k, wrap_1, (k == 10));
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (seg_1 !== exp_pat[k % 10]) $display("FAIL up_seg step %0d: got %b expected %b", k, seg_1, exp_pat[k % 10]);
      else pass_cnt++;
      total_cnt++;
      if (wrap_1 !== 1'b0) $display("FAIL up_wrap_len step %0d: got %b expected 0", k, wrap_1);
      else pass_cnt++;
      repeat (3) @(negedge clock);
    end
  endtask

  task automatic test_carry_wrap();
    up = 1'b1;
    do_load(16'h0999);
    total_cnt++; if (cnt_d !== 16'h0999) $display("FAIL carry_load: got %h expected 0999", cnt_d); else pass_cnt++;
    repeat (3) @(negedge clock);
    total_cnt++; if (cnt_d !== 16'h0999) $display("FAIL carry_hold: got %h expected 0999", cnt_d); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (cnt_d !== 16'h1000) $display("FAIL carry_step: got %h expected 1000", cnt_d); else pass_cnt++;
    total_cnt++; if (wrap_d !== 1'b0) $display("FAIL carry_nowrap: got %b expected 0", wrap_d); else pass_cnt++;
    do_load(16'h9999);
    repeat (4) @(negedge clock);
    total_cnt++; if (cnt_d !== 16'h0000) $display("FAIL wrap_up_count: got %h expected 0000", cnt_d); else pass_cnt++;
    total_cnt++; if (wrap_d !== 1'b1) $display("FAIL wrap_up_pulse: got %b expected 1", wrap_d); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (wrap_d !== 1'b0) $display("FAIL wrap_up_len: got %b expected 0", wrap_d); else pass_cnt++;
  endtask

  task automatic test_down_borrow();
    up = 1'b0;
    do_load(16'h1000);
    repeat (4) @(negedge clock);
    total_cnt++; if (cnt_d !== 16'h0999) $display("FAIL borrow_step: got %h expected 0999", cnt_d); else pass_cnt++;
    total_cnt++; if (wrap_d !== 1'b0) $display("FAIL borrow_nowrap: got %b expected 0", wrap_d); else pass_cnt++;
    do_load(16'h0000);
    repeat (4) @(negedge clock);
    total_cnt++; if (cnt_d !== 16'h9999) $display("FAIL wrap_down_count: got %h expected 9999", cnt_d); else pass_cnt++;
    total_cnt++; if (wrap_d !== 1'b1) $display("FAIL wrap_down_pulse: got %b expected 1", wrap_d); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (wrap_d !== 1'b0) $display("FAIL wrap_down_len: got %b expected 0", wrap_d); else pass_cnt++;
  endtask

  task automatic test_scan_blank();
    logic [6:0] exp_scan [4];
    logic [3:0] exp_dig;
    en = 1'b0;
    blank_lz = 1'b1;
    do_load(16'h0042);
    total_cnt++; if (cnt_d !== 16'h0042) $display("FAIL scan_load: got %h expected 0042", cnt_d); else pass_cnt++;
    exp_scan[0] = 7'b0010010;
    exp_scan[1] = 7'b1001100;
    exp_scan[2] = 7'h7F;
    exp_scan[3] = 7'h7F;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        blank_lz = 1'b0;
        exp_scan[2] = 7'b0000001;
        exp_scan[3] = 7'b0000001;
      end
      sync_digit0();
      for (int k = 0; k < 12; k++) begin
        exp_dig = 4'b0001 << (k / 3);
        total_cnt++;
        if (dig_d !== exp_dig) $display("FAIL scan_dig blank=%0d cyc %0d: got %b expected %b", blank_lz, k, dig_d, exp_dig);
        else pass_cnt++;
        total_cnt++;
        if (seg_d !== exp_scan[k / 3]) $display("FAIL scan_seg blank=%0d cyc %0d: got %b expected %b", blank_lz, k, seg_d, exp_scan[k / 3]);
        else pass_cnt++;
        @(negedge clock);
      end
    end
    total_cnt++; if (cnt_d !== 16'h0042) $display("FAIL en_low_hold: got %h expected 0042", cnt_d); else pass_cnt++;
  endtask

  task automatic test_load_clamp();
    en = 1'b1;
    up = 1'b1;
    do_load(16'h0100);
    repeat (3) @(negedge clock);
    do_load(16'h0555);
    total_cnt++; if (cnt_d !== 16'h0555) $display("FAIL load_prio: got %h expected 0555", cnt_d); else pass_cnt++;
    total_cnt++; if (wrap_d !== 1'b0) $display("FAIL load_nowrap: got %b expected 0", wrap_d); else pass_cnt++;
    repeat (3) @(negedge clock);
    total_cnt++; if (cnt_d !== 16'h0555) $display("FAIL load_presc_clear: got %h expected 0555", cnt_d); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (cnt_d !== 16'h0556) $display("FAIL load_then_tick: got %h expected 0556", cnt_d); else pass_cnt++;
    en = 1'b0;
    do_load(16'h00AF);
    total_cnt++; if (cnt_d !== 16'h0099) $display("FAIL bcd_clamp: got %h expected 0099", cnt_d); else pass_cnt++;
    total_cnt++; if (cnt_h !== 16'h00AF) $display("FAIL hex_noclamp: got %h expected 00af", cnt_h); else pass_cnt++;
    sync_digit0();
    total_cnt++; if (seg_d !== exp_pat[9]) $display("FAIL clamp_seg0: got %b expected %b", seg_d, exp_pat[9]); else pass_cnt++;
    total_cnt++; if (seg_h !== exp_pat[15]) $display("FAIL hex_seg_F: got %b expected %b", seg_h, exp_pat[15]); else pass_cnt++;
    repeat (3) @(negedge clock);
    total_cnt++; if (seg_h !== exp_pat[10]) $display("FAIL hex_seg_A: got %b expected %b", seg_h, exp_pat[10]); else pass_cnt++;
    total_cnt++; if (dig_h !== 4'b0010) $display("FAIL hex_dig1: got %b expected 0010", dig_h); else pass_cnt++;
  endtask

  task automatic test_hex_reset();
    en = 1'b1;
    up = 1'b1;
    do_load(16'h000F);
    repeat (4) @(negedge clock);
    en = 1'b0;
    total_cnt++; if (cnt_h !== 16'h0010) $display("FAIL hex_carry: got %h expected 0010", cnt_h); else pass_cnt++;
    total_cnt++; if (wrap_h !== 1'b0) $display("FAIL hex_nowrap: got %b expected 0", wrap_h); else pass_cnt++;
    sync_digit0();
    total_cnt++; if (seg_h !== 7'b0000001) $display("FAIL hex_seg_d0: got %b expected 0000001", seg_h); else pass_cnt++;
    repeat (3) @(negedge clock);
    total_cnt++; if (seg_h !== 7'b1001111) $display("FAIL hex_seg_d1: got %b expected 1001111", seg_h); else pass_cnt++;
    en = 1'b1;
    repeat (2) @(negedge clock);
    resetb = 1'b0;
    @(negedge clock);
    total_cnt++; if (seg_d !== 7'h7F) $display("FAIL midreset_seg: got %b expected %b", seg_d, 7'h7F); else pass_cnt++;
    total_cnt++; if (dig_d !== 4'b0000) $display("FAIL midreset_dig: got %b expected 0000", dig_d); else pass_cnt++;
    total_cnt++; if (cnt_h !== 16'h0000) $display("FAIL midreset_count: got %h expected 0000", cnt_h); else pass_cnt++;
    total_cnt++; if (wrap_d !== 1'b0) $display("FAIL midreset_wrap: got %b expected 0", wrap_d); else pass_cnt++;
    resetb = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_decimal_up();
    test_carry_wrap();
    test_down_borrow();
    test_scan_blank();
    test_load_clamp();
    test_hex_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
